// File: rtl/stg_wb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : stg_wb_pkg
// Purpose : Shared sizes, opcodes and the stage-register layout of the amber
//           write-back stage.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package stg_wb_pkg;

  localparam int N_GP        = 16;
  localparam int N_SR        = 4;
  localparam int N_AR        = 4;
  localparam int HBIT_TGT_GP = 3;
  localparam int HBIT_TGT_SR = 1;
  localparam int HBIT_TGT_AR = 1;
  localparam int HBIT_OPC    = 7;

  localparam logic [HBIT_OPC:0] OPC_NOP   = 8'h00;
  localparam logic [HBIT_OPC:0] OPC_LDAso = 8'h2C;

  // Everything MO hands over, held for one commit.
  typedef struct packed {
    logic [47:0]          pc;
    logic [23:0]          instr;
    logic [HBIT_OPC:0]    opc;
    logic [HBIT_TGT_GP:0] tgt_gp;
    logic                 tgt_gp_we;
    logic [HBIT_TGT_SR:0] tgt_sr;
    logic                 tgt_sr_we;
    logic [HBIT_TGT_AR:0] tgt_ar;
    logic                 tgt_ar_we;
    logic [23:0]          result;
    logic [47:0]          sr_result;
    logic [47:0]          ar_result;
  } wb_stage_t;

endpackage
`default_nettype wire

// File: rtl/stg_wb_regfile_wf.sv
`default_nettype none
// ============================================================================
// Module  : regfile_wf
// Purpose : Flop-based register file with one write port, RD combinational
//           read ports and write-first bypass.
// Ports   : clk, rst (async, active-high)
//           we / waddr / wdata        - write port, takes effect at posedge
//           raddr [RD*AW]             - packed read indices, port 0 in LSBs
//           rdata [RD*WIDTH]          - packed read data, port 0 in LSBs
// Revision: 1.0 - initial release
// ============================================================================
module regfile_wf #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 24,
  parameter int RD    = 2,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [AW-1:0]       waddr,
  input  logic [WIDTH-1:0]    wdata,
  input  logic [RD*AW-1:0]    raddr,
  output logic [RD*WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem <= '{default: '0};
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // A write pending this cycle wins over the stored contents, so a reader
  // never sees the stale value one cycle before the array catches up.
  for (genvar r = 0; r < RD; r++) begin : g_rd
    logic [AW-1:0] idx;
    assign idx = raddr[r*AW +: AW];
    assign rdata[r*WIDTH +: WIDTH] = (we && (waddr == idx)) ? wdata : mem[idx];
  end

endmodule
`default_nettype wire

// File: rtl/stg_wb.sv
`default_nettype none
// ============================================================================
// Module  : stg_wb
// Purpose : Amber write-back stage. Registers the MO outputs, commits GP/SR/AR
//           results, serves decode register reads with write-first bypass,
//           publishes the committing write for forwarding and counts retired
//           instructions.
// Ports   : iw_clk, iw_rst (async, active-high), iw_stall
//           iw_* MO fields            - captured into the stage register
//           iw_rd_* / ow_rd_*         - decode register reads (combinational)
//           ow_fwd_*                  - committing target/enable/value
//           ow_pc, ow_opc             - captured pc/opcode for trace
//           or_retired                - 48-bit retired-instruction counter
// Revision: 1.0 - initial release
// ============================================================================
module stg_wb
  import stg_wb_pkg::*;
(
  input  logic                 iw_clk,
  input  logic                 iw_rst,
  input  logic                 iw_stall,
  input  logic [47:0]          iw_pc,
  input  logic [23:0]          iw_instr,
  input  logic [HBIT_OPC:0]    iw_opc,
  input  logic [HBIT_TGT_GP:0] iw_tgt_gp,
  input  logic                 iw_tgt_gp_we,
  input  logic [HBIT_TGT_SR:0] iw_tgt_sr,
  input  logic                 iw_tgt_sr_we,
  input  logic [HBIT_TGT_AR:0] iw_tgt_ar,
  input  logic                 iw_tgt_ar_we,
  input  logic [23:0]          iw_result,
  input  logic [47:0]          iw_sr_result,
  input  logic [47:0]          iw_ar_result,
  input  logic [HBIT_TGT_GP:0] iw_rd_gp_a,
  input  logic [HBIT_TGT_GP:0] iw_rd_gp_b,
  output logic [23:0]          ow_rd_gp_a,
  output logic [23:0]          ow_rd_gp_b,
  input  logic [HBIT_TGT_SR:0] iw_rd_sr,
  input  logic [HBIT_TGT_AR:0] iw_rd_ar,
  output logic [47:0]          ow_rd_sr,
  output logic [47:0]          ow_rd_ar,
  output logic [HBIT_TGT_GP:0] ow_fwd_gp,
  output logic                 ow_fwd_gp_we,
  output logic [23:0]          ow_fwd_gp_val,
  output logic [HBIT_TGT_SR:0] ow_fwd_sr,
  output logic                 ow_fwd_sr_we,
  output logic [47:0]          ow_fwd_sr_val,
  output logic [HBIT_TGT_AR:0] ow_fwd_ar,
  output logic                 ow_fwd_ar_we,
  output logic [47:0]          ow_fwd_ar_val,
  output logic [47:0]          ow_pc,
  output logic [HBIT_OPC:0]    ow_opc,
  output logic [47:0]          or_retired
);

  wb_stage_t   stage;
  wb_stage_t   stage_d;
  logic        gp_we;
  logic        sr_we;
  logic        ar_we;
  logic [47:0] retired;

  assign stage_d = '{
    pc:        iw_pc,
    instr:     iw_instr,
    opc:       iw_opc,
    tgt_gp:    iw_tgt_gp,
    tgt_gp_we: iw_tgt_gp_we,
    tgt_sr:    iw_tgt_sr,
    tgt_sr_we: iw_tgt_sr_we,
    tgt_ar:    iw_tgt_ar,
    tgt_ar_we: iw_tgt_ar_we,
    result:    iw_result,
    sr_result: iw_sr_result,
    ar_result: iw_ar_result
  };

  // Stage register: a stall freezes the captured instruction so it stays
  // pending and commits at the first unstalled edge.
  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) begin
      stage <= '0;
    end else if (!iw_stall) begin
      stage <= stage_d;
    end
  end

  // Stall suppresses the write, the bypass and the forwarding enable alike,
  // so nothing downstream sees a commit that has not happened yet.
  assign gp_we = stage.tgt_gp_we & ~iw_stall;
  assign sr_we = stage.tgt_sr_we & ~iw_stall;
  assign ar_we = stage.tgt_ar_we & ~iw_stall;

  // The instruction committing at this edge is counted here; since the stage
  // register only reloads on the same unstalled edge, each one counts once.
  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) begin
      retired <= '0;
    end else if (!iw_stall && (stage.opc != OPC_NOP)) begin
      retired <= retired + 48'd1;
    end
  end

  regfile_wf #(.DEPTH(N_GP), .WIDTH(24), .RD(2), .AW(HBIT_TGT_GP + 1)) u_rf_gp (
    .clk   (iw_clk),
    .rst   (iw_rst),
    .we    (gp_we),
    .waddr (stage.tgt_gp),
    .wdata (stage.result),
    .raddr ({iw_rd_gp_b, iw_rd_gp_a}),
    .rdata ({ow_rd_gp_b, ow_rd_gp_a})
  );

  regfile_wf #(.DEPTH(N_SR), .WIDTH(48), .RD(1), .AW(HBIT_TGT_SR + 1)) u_rf_sr (
    .clk   (iw_clk),
    .rst   (iw_rst),
    .we    (sr_we),
    .waddr (stage.tgt_sr),
    .wdata (stage.sr_result),
    .raddr (iw_rd_sr),
    .rdata (ow_rd_sr)
  );

  regfile_wf #(.DEPTH(N_AR), .WIDTH(48), .RD(1), .AW(HBIT_TGT_AR + 1)) u_rf_ar (
    .clk   (iw_clk),
    .rst   (iw_rst),
    .we    (ar_we),
    .waddr (stage.tgt_ar),
    .wdata (stage.ar_result),
    .raddr (iw_rd_ar),
    .rdata (ow_rd_ar)
  );

  assign ow_fwd_gp     = iw_stall ? '0 : stage.tgt_gp;
  assign ow_fwd_gp_we  = gp_we;
  assign ow_fwd_gp_val = iw_stall ? '0 : stage.result;
  assign ow_fwd_sr     = iw_stall ? '0 : stage.tgt_sr;
  assign ow_fwd_sr_we  = sr_we;
  assign ow_fwd_sr_val = iw_stall ? '0 : stage.sr_result;
  assign ow_fwd_ar     = iw_stall ? '0 : stage.tgt_ar;
  assign ow_fwd_ar_we  = ar_we;
  assign ow_fwd_ar_val = iw_stall ? '0 : stage.ar_result;

  assign ow_pc      = stage.pc;
  assign ow_opc     = stage.opc;
  assign or_retired = retired;

  // The raw instruction word travels with the stage but has no consumer here.
  logic unused_instr;
  assign unused_instr = ^stage.instr;

endmodule
`default_nettype wire

// File: tb/tb_stg_wb.sv
`default_nettype none
// ============================================================================
// Module  : tb_stg_wb
// Purpose : Self-checking bench for stg_wb. Expected values are queued when a
//           transaction is driven and popped when the DUT output is sampled.
// Revision: 1.0 - initial release
// ============================================================================
module tb_stg_wb;
  import stg_wb_pkg::*;

  logic                 clk;
  logic                 rst;
  logic                 stall;
  logic [47:0]          pc;
  logic [23:0]          instr;
  logic [HBIT_OPC:0]    opc;
  logic [HBIT_TGT_GP:0] tgt_gp;
  logic                 tgt_gp_we;
  logic [HBIT_TGT_SR:0] tgt_sr;
  logic                 tgt_sr_we;
  logic [HBIT_TGT_AR:0] tgt_ar;
  logic                 tgt_ar_we;
  logic [23:0]          result;
  logic [47:0]          sr_result;
  logic [47:0]          ar_result;
  logic [HBIT_TGT_GP:0] rd_gp_a_idx, rd_gp_b_idx;
  logic [23:0]          rd_gp_a, rd_gp_b;
  logic [HBIT_TGT_SR:0] rd_sr_idx;
  logic [HBIT_TGT_AR:0] rd_ar_idx;
  logic [47:0]          rd_sr, rd_ar;
  logic [HBIT_TGT_GP:0] fwd_gp;
  logic                 fwd_gp_we;
  logic [23:0]          fwd_gp_val;
  logic [HBIT_TGT_SR:0] fwd_sr;
  logic                 fwd_sr_we;
  logic [47:0]          fwd_sr_val;
  logic [HBIT_TGT_AR:0] fwd_ar;
  logic                 fwd_ar_we;
  logic [47:0]          fwd_ar_val;
  logic [47:0]          out_pc;
  logic [HBIT_OPC:0]    out_opc;
  logic [47:0]          retired;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [47:0] expq[$];

  stg_wb dut (
    .iw_clk        (clk),
    .iw_rst        (rst),
    .iw_stall      (stall),
    .iw_pc         (pc),
    .iw_instr      (instr),
    .iw_opc        (opc),
    .iw_tgt_gp     (tgt_gp),
    .iw_tgt_gp_we  (tgt_gp_we),
    .iw_tgt_sr     (tgt_sr),
    .iw_tgt_sr_we  (tgt_sr_we),
    .iw_tgt_ar     (tgt_ar),
    .iw_tgt_ar_we  (tgt_ar_we),
    .iw_result     (result),
    .iw_sr_result  (sr_result),
    .iw_ar_result  (ar_result),
    .iw_rd_gp_a    (rd_gp_a_idx),
    .iw_rd_gp_b    (rd_gp_b_idx),
    .ow_rd_gp_a    (rd_gp_a),
    .ow_rd_gp_b    (rd_gp_b),
    .iw_rd_sr      (rd_sr_idx),
    .iw_rd_ar      (rd_ar_idx),
    .ow_rd_sr      (rd_sr),
    .ow_rd_ar      (rd_ar),
    .ow_fwd_gp     (fwd_gp),
    .ow_fwd_gp_we  (fwd_gp_we),
    .ow_fwd_gp_val (fwd_gp_val),
    .ow_fwd_sr     (fwd_sr),
    .ow_fwd_sr_we  (fwd_sr_we),
    .ow_fwd_sr_val (fwd_sr_val),
    .ow_fwd_ar     (fwd_ar),
    .ow_fwd_ar_we  (fwd_ar_we),
    .ow_fwd_ar_val (fwd_ar_val),
    .ow_pc         (out_pc),
    .ow_opc        (out_opc),
    .or_retired    (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  task automatic push(input logic [47:0] v);
    expq.push_back(v);
  endtask

  task automatic check(input string tag, input logic [47:0] obs);
    logic [47:0] exp;
    n_assert++;
    if (expq.size() == 0) begin
      n_fail++;
      $error("FAIL %s observed=%h expected=<scoreboard empty>", tag, obs);
    end else begin
      exp = expq.pop_front();
      assert (obs === exp) else begin
        n_fail++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_nop();
    pc = '0; instr = '0; opc = OPC_NOP;
    tgt_gp = '0; tgt_gp_we = 1'b0; result = '0;
    tgt_sr = '0; tgt_sr_we = 1'b0; sr_result = '0;
    tgt_ar = '0; tgt_ar_we = 1'b0; ar_result = '0;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0;
    drive_nop();
    rd_gp_a_idx = '0; rd_gp_b_idx = '0; rd_sr_idx = '0; rd_ar_idx = '0;
    repeat (2) @(posedge clk);
    #4 rst = 1'b0;

    // Reset state
    push(48'h0); push(48'h0); push(48'h0); push(48'h0);
    #1;
    check("reset_retired", retired);
    check("reset_fwd_ar_val", fwd_ar_val);
    check("reset_rd_gp_a", {24'h0, rd_gp_a});
    check("reset_opc", {40'h0, out_opc});

    // AR commit with bypass, then from the array
    tick();
    opc = OPC_LDAso; tgt_ar = 2'd2; tgt_ar_we = 1'b1; ar_result = 48'hCAFEBE_987654;
    rd_ar_idx = 2'd2;
    push(48'hCAFEBE_987654); push(48'h1); push(48'h0);
    push(48'hCAFEBE_987654); push(48'h1);
    tick();
    drive_nop();
    check("ar_bypass", rd_ar);
    check("ar_fwd_we", {47'h0, fwd_ar_we});
    check("ar_retired_pending", retired);
    tick();
    check("ar_array", rd_ar);
    check("ar_retired", retired);

    // Simultaneous GP/SR/AR commits
    opc = OPC_LDAso;
    tgt_gp = 4'd5; tgt_gp_we = 1'b1; result = 24'h123456;
    tgt_sr = 2'd1; tgt_sr_we = 1'b1; sr_result = 48'h1;
    tgt_ar = 2'd0; tgt_ar_we = 1'b1; ar_result = 48'hFFFF_FFFF_FFFF;
    rd_gp_a_idx = 4'd5; rd_gp_b_idx = 4'd5; rd_sr_idx = 2'd1; rd_ar_idx = 2'd0;
    push(48'h123456); push(48'h123456); push(48'h1); push(48'hFFFF_FFFF_FFFF);
    push(48'h2);
    tick();
    drive_nop();
    tick();
    check("multi_gp_a", {24'h0, rd_gp_a});
    check("multi_gp_b", {24'h0, rd_gp_b});
    check("multi_sr", rd_sr);
    check("multi_ar", rd_ar);
    check("multi_retired", retired);

    // Bypass priority over stored GP3
    opc = OPC_LDAso; tgt_gp = 4'd3; tgt_gp_we = 1'b1; result = 24'hAAAAAA;
    rd_gp_a_idx = 4'd3; rd_gp_b_idx = 4'd3;
    tick();
    result = 24'h555555;
    push(48'h555555); push(48'h555555); push(48'h3);
    push(48'h555555); push(48'h4);
    tick();
    drive_nop();
    check("bypass_gp_a", {24'h0, rd_gp_a});
    check("bypass_gp_b", {24'h0, rd_gp_b});
    check("bypass_retired", retired);
    tick();
    check("bypass_array", {24'h0, rd_gp_a});
    check("bypass_retired_after", retired);

    // Stall holds a pending GP7 write for three edges
    opc = OPC_LDAso; tgt_gp = 4'd7; tgt_gp_we = 1'b1; result = 24'h777777;
    rd_gp_a_idx = 4'd7;
    tick();
    drive_nop();
    stall = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      push(48'h0); push(48'h0); push(48'h4);
      check("stall_gp7", {24'h0, rd_gp_a});
      check("stall_fwd_we", {47'h0, fwd_gp_we});
      check("stall_retired", retired);
      tick();
    end
    stall = 1'b0;
    push(48'h777777); push(48'h5);
    tick();
    check("stall_gp7_commit", {24'h0, rd_gp_a});
    check("stall_retired_once", retired);

    // Retire counter wrap
    force dut.retired = 48'hFFFF_FFFF_FFFF;
    #1;
    release dut.retired;
    push(48'hFFFF_FFFF_FFFF); push(48'hFFFF_FFFF_FFFF); push(48'h0); push(48'h0);
    check("wrap_preload", retired);
    opc = OPC_LDAso;
    tick();
    drive_nop();
    check("wrap_pending", retired);
    tick();
    check("wrap_zero", retired);
    tick();
    check("wrap_nop_hold", retired);

    // Reset asserted while a GP9 write is pending
    opc = OPC_LDAso; pc = 48'h0000_1234_5678;
    tgt_gp = 4'd9; tgt_gp_we = 1'b1; result = 24'hABCDEF;
    rd_gp_a_idx = 4'd9; rd_gp_b_idx = 4'd5; rd_sr_idx = 2'd1; rd_ar_idx = 2'd0;
    push(48'hABCDEF); push(48'hABCDEF);
    push(48'h0); push(48'h0); push(48'h0); push(48'h0); push(48'h0); push(48'h0);
    push(48'h0);
    push(48'h0);
    tick();
    drive_nop();
    check("rstmid_bypass", {24'h0, rd_gp_a});
    check("rstmid_fwd_val", {24'h0, fwd_gp_val});
    #2 rst = 1'b1;
    #1;
    check("rst_rd_gp_a", {24'h0, rd_gp_a});
    check("rst_rd_gp_b", {24'h0, rd_gp_b});
    check("rst_rd_sr", rd_sr);
    check("rst_rd_ar", rd_ar);
    check("rst_fwd_gp_val", {24'h0, fwd_gp_val});
    check("rst_retired", retired);
    check("rst_pc", out_pc);
    #1 rst = 1'b0;
    tick();
    check("rst_discard_gp9", {24'h0, rd_gp_a});

    if (expq.size() != 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", expq.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
